if_id_stage: RTL and testbench
==============================

// Module: if_id_stage
// PURPOSE
//  Parametrised IF/ID pipeline register with a valid bit, stall (hold) and flush (bubble).
//  Captures the fetched instruction word and PC+4, then presents pre-split decode fields to the ID stage.
//  Sits between the fetch unit and the register file / control decode.
//  The hazard unit drives Stall; branch/jump resolution drives Flush.
// PARAMETERS
//  INS_W     32  instruction word width; field slices below assume the MIPS-32 layout
//  PC_W      30  width of the word-aligned PC+4 (bits [31:2])
//  CNT_W     16  width of the stall/flush event counters (PERF_CNT_EN only)
// PORTS
//  Clk          in   1      clock; all state updates on posedge
//  Rst          in   1      synchronous reset, active-high
//  ins          in   INS_W  fetched instruction
//  PC_plus_4    in   PC_W   fetch-stage PC+4, word address
//  in_valid     in   1      fetch output is a real instruction
//  Stall        in   1      hold all ID registers this cycle
//  Flush        in   1      replace ID contents with a bubble
//  id_valid     out  1      ID stage holds a real instruction
//  id_ins       out  INS_W  raw instruction word
//  op           out  6      ins[31:26]
//  Ra           out  5      ins[25:21]
//  Rb           out  5      ins[20:16]
//  Rw           out  5      ins[15:11]
//  shamt        out  5      ins[10:6]
//  funct        out  6      ins[5:0]
//  imm16        out  16     ins[15:0]
//  id_PC_plus_4 out  PC_W   PC+4 travelling with the instruction
//  held         out  1      1 while the FSM is in HOLD
//  stall_cnt    out  CNT_W  count of stalled cycles (0 unless PERF_CNT_EN)
//  flush_cnt    out  CNT_W  count of flushes (0 unless PERF_CNT_EN)
// BEHAVIOUR
//  - Reset: every output is 0, including id_ins = 0 (SLL $0 = NOP); FSM goes to RUN.
//  - Priority each posedge: Rst > Flush > Stall > load.
//  - Load (no Rst/Flush/Stall): all fields take the current ins/PC_plus_4; id_valid <= in_valid.
//    Latency is 1 cycle.
//  - Stall: all outputs hold their values, including id_valid.
//  - Flush: id_valid <= 0, id_ins and all field outputs <= 0, id_PC_plus_4 <= 0.
//    Flush with Stall in the same cycle: flush wins, and the bubble is written.
//  - in_valid=0 with a load: id_valid=0, and fields still load (don't-care downstream).
//  - Fields are pure slices of the registered id_ins, so they are always mutually consistent.
//  - FSM: RUN -> HOLD when Stall&!Flush; HOLD stays while Stall&!Flush; HOLD -> RUN when !Stall or Flush.
//    held = (state==HOLD); Rst -> RUN from either state.
//  - Rst mid-stall: the next cycle shows reset values, and the prior contents are discarded.
// CONFIGURATION
//  - IF_ID_PERF_CNT_EN defined:
//    stall_cnt increments on every posedge with Stall&!Flush&!Rst.
//    flush_cnt increments on every posedge with Flush&!Rst.
//    Both saturate at all-ones (no wrap) and clear on Rst.
//  - IF_ID_PERF_CNT_EN undefined: counters are not built; stall_cnt and flush_cnt are tied to 0.
//    Port list is unchanged.
// STRUCTURE
//  - Shared package/header pipe_defs: field bit positions (OP_HI/OP_LO ... IMM_HI/IMM_LO),
//    NOP_INS = 32'h0000_0000, FSM state encodings RUN=1'b0, HOLD=1'b1.
//  - Sub-module sat_counter (params W; ports Clk, Rst, inc, cnt), instantiated twice under the macro.
//  - No other hierarchy; the field split is combinational from id_ins.
// TESTING
//  1. Rst=1 for 2 cycles -> all outputs 0, held=0.
//     Then ins=32'h8C22_0004, PC_plus_4=30'h4, in_valid=1 -> next cycle: op=6'h23, Ra=1, Rb=2,
//     imm16=16'h0004, id_PC_plus_4=30'h4, id_valid=1.
//  2. Load 32'h0022_1820, then Stall=1 for 3 cycles while ins changes -> outputs stay Rw=3,
//     funct=6'h20, held=1 for 3 cycles; held=0 the cycle after Stall drops.
//  3. Flush=1 with a valid instruction registered -> next cycle id_valid=0, id_ins=0, Ra=Rb=Rw=0.
//  4. Stall=1 and Flush=1 together -> bubble written (id_valid=0), held=0.
//  5. Assert Rst while in HOLD -> next cycle all outputs 0 and held=0; stall_cnt=0 if the counters are built.
//  6. With IF_ID_PERF_CNT_EN and CNT_W=2: 5 stalled cycles -> stall_cnt=3 (saturated); 2 flushes -> flush_cnt=2.
//     Without the macro, both read 0 throughout.

Source files
------------

// File: rtl/pipe_defs.sv
// Shared IF/ID definitions: MIPS-32 field positions,
// the reset/bubble instruction and the stage FSM states.
package pipe_defs;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RA_HI    = 25;
  localparam int RA_LO    = 21;
  localparam int RB_HI    = 20;
  localparam int RB_LO    = 16;
  localparam int RW_HI    = 15;
  localparam int RW_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bundle: fetch/hazard inputs and the
// registered, pre-split decode fields.
interface if_id_stage_if #(
  parameter int INS_W = 32,
  parameter int PC_W  = 30,
  parameter int CNT_W = 16
);
  logic [INS_W-1:0] ins;
  logic [PC_W-1:0]  PC_plus_4;
  logic             in_valid;
  logic             Stall;
  logic             Flush;

  logic             id_valid;
  logic [INS_W-1:0] id_ins;
  logic [5:0]       op;
  logic [4:0]       Ra;
  logic [4:0]       Rb;
  logic [4:0]       Rw;
  logic [4:0]       shamt;
  logic [5:0]       funct;
  logic [15:0]      imm16;
  logic [PC_W-1:0]  id_PC_plus_4;
  logic             held;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ins, PC_plus_4, in_valid,
    output Stall, Flush,
    input  id_valid, id_ins,
    input  op, Ra, Rb, Rw,
    input  shamt, funct, imm16,
    input  id_PC_plus_4, held,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  ins, PC_plus_4, in_valid,
    input  Stall, Flush,
    output id_valid, id_ins,
    output op, Ra, Rb, Rw,
    output shamt, funct, imm16,
    output id_PC_plus_4, held,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of
// wrapping; cleared by synchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count up on inc, stop at the maximum value
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid, stall-hold and
// flush-bubble. Optional counters: IF_ID_PERF_CNT_EN.
module if_id_stage
  import pipe_defs::*;
#(
  parameter int INS_W = 32,
  parameter int PC_W  = 30,
  parameter int CNT_W = 16
) (
  input logic          Clk,
  input logic          Rst,
  if_id_stage_if.slave bus
);

  logic             valid_q;
  logic [INS_W-1:0] ins_q;
  logic [PC_W-1:0]  pc_q;
  state_e           state_q;
  state_e           state_d;
  logic             stall_ev;

  assign stall_ev = bus.Stall && !bus.Flush;

  // pipeline register: reset > flush > stall > load
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= 1'b0;
      ins_q   <= INS_W'(NOP_INS);
      pc_q    <= '0;
    end else if (bus.Flush) begin
      valid_q <= 1'b0;
      ins_q   <= INS_W'(NOP_INS);
      pc_q    <= '0;
    end else if (!bus.Stall) begin
      valid_q <= bus.in_valid;
      ins_q   <= bus.ins;
      pc_q    <= bus.PC_plus_4;
    end
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HOLD while stalled and not flushed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (stall_ev) state_d = HOLD;
      end
      HOLD: begin
        if (!stall_ev) state_d = RUN;
      end
    endcase
  end

  assign bus.held         = (state_q == HOLD);
  assign bus.id_valid     = valid_q;
  assign bus.id_ins       = ins_q;
  assign bus.id_PC_plus_4 = pc_q;
  assign bus.op           = ins_q[OP_HI:OP_LO];
  assign bus.Ra           = ins_q[RA_HI:RA_LO];
  assign bus.Rb           = ins_q[RB_HI:RB_LO];
  assign bus.Rw           = ins_q[RW_HI:RW_LO];
  assign bus.shamt        = ins_q[SHAMT_HI:SHAMT_LO];
  assign bus.funct        = ins_q[FUNCT_HI:FUNCT_LO];
  assign bus.imm16        = ins_q[IMM_HI:IMM_LO];

`ifdef IF_ID_PERF_CNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .Clk (Clk),
    .Rst (Rst),
    .inc (stall_ev),
    .cnt (bus.stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .Clk (Clk),
    .Rst (Rst),
    .inc (bus.Flush),
    .cnt (bus.flush_cnt)
  );
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Randomised bench for if_id_stage against a
// behavioural model of the IF/ID register.
module tb_if_id_stage;

  localparam int INS_W = 32;
  localparam int PC_W  = 30;
  localparam int CNT_W = 2;

  logic Clk = 1'b0;
  logic Rst;

  always #5 Clk = ~Clk;

  if_id_stage_if #(
    .INS_W (INS_W),
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) bus ();

  if_id_stage #(
    .INS_W (INS_W),
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  bit          m_valid;
  logic [31:0] m_ins;
  logic [29:0] m_pc;
  bit          m_held;
  int          m_sc;
  int          m_fc;
  int          cmax;
  int          n_chk;
  int          n_pass;
  bit          chk_en;

  function automatic void check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endfunction

  task automatic step(
    input bit          r,
    input bit          f,
    input bit          s,
    input bit          v,
    input logic [31:0] i,
    input logic [29:0] p
  );
    Rst           = r;
    bus.Flush     = f;
    bus.Stall     = s;
    bus.in_valid  = v;
    bus.ins       = i;
    bus.PC_plus_4 = p;
    @(posedge Clk);
    if (r) begin
      m_valid = 0; m_ins = 0; m_pc = 0;
      m_held = 0; m_sc = 0; m_fc = 0;
    end else if (f) begin
      m_valid = 0; m_ins = 0; m_pc = 0;
      m_held = 0;
`ifdef IF_ID_PERF_CNT_EN
      m_fc = (m_fc < cmax) ? m_fc + 1 : cmax;
`endif
    end else if (s) begin
      m_held = 1;
`ifdef IF_ID_PERF_CNT_EN
      m_sc = (m_sc < cmax) ? m_sc + 1 : cmax;
`endif
    end else begin
      m_valid = v; m_ins = i; m_pc = p;
      m_held = 0;
    end
    #2;
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("id_valid", bus.id_valid, m_valid);
      check("id_ins", bus.id_ins, m_ins);
      check("op", bus.op, (m_ins / (1 << 26)) % 64);
      check("Ra", bus.Ra, (m_ins / (1 << 21)) % 32);
      check("Rb", bus.Rb, (m_ins / (1 << 16)) % 32);
      check("Rw", bus.Rw, (m_ins / (1 << 11)) % 32);
      check("shamt", bus.shamt, (m_ins / 64) % 32);
      check("funct", bus.funct, m_ins % 64);
      check("imm16", bus.imm16, m_ins % 65536);
      check("pc", bus.id_PC_plus_4, m_pc);
      check("held", bus.held, m_held);
      check("stall_cnt", bus.stall_cnt, m_sc);
      check("flush_cnt", bus.flush_cnt, m_fc);
    end
  end

  initial begin
    cmax = (1 << CNT_W) - 1;
    n_chk = 0; n_pass = 0; chk_en = 0;
    m_sc = 0; m_fc = 0;

    // reset for two cycles
    step(1, 0, 0, 0, 32'h0, 30'h0);
    chk_en = 1;
    step(1, 0, 0, 0, 32'h0, 30'h0);
    check("rst_ins", bus.id_ins, 0);
    check("rst_held", bus.held, 0);
    check("rst_valid", bus.id_valid, 0);

    // 1: lw load, one-cycle latency
    step(0, 0, 0, 1, 32'h8C22_0004, 30'h4);
    check("t1_op", bus.op, 6'h23);
    check("t1_Ra", bus.Ra, 5'd1);
    check("t1_Rb", bus.Rb, 5'd2);
    check("t1_imm", bus.imm16, 16'h0004);
    check("t1_pc", bus.id_PC_plus_4, 30'h4);
    check("t1_valid", bus.id_valid, 1);

    // 2: add, then three stalled cycles
    step(0, 0, 0, 1, 32'h0022_1820, 30'h8);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, $urandom, 30'($urandom));
      check("t2_Rw", bus.Rw, 5'd3);
      check("t2_funct", bus.funct, 6'h20);
      check("t2_held", bus.held, 1);
    end
    step(0, 0, 0, 1, 32'h0000_0000, 30'hC);
    check("t2_unheld", bus.held, 0);

    // 3: flush a valid instruction
    step(0, 0, 0, 1, 32'h0043_2025, 30'h10);
    step(0, 1, 0, 1, 32'h1234_5678, 30'h14);
    check("t3_valid", bus.id_valid, 0);
    check("t3_ins", bus.id_ins, 0);
    check("t3_Ra", bus.Ra, 0);
    check("t3_Rb", bus.Rb, 0);
    check("t3_Rw", bus.Rw, 0);

    // 4: stall and flush together
    step(0, 0, 0, 1, 32'h0064_2820, 30'h18);
    step(0, 0, 1, 1, 32'hDEAD_BEEF, 30'h1C);
    step(0, 1, 1, 1, 32'hDEAD_BEEF, 30'h1C);
    check("t4_valid", bus.id_valid, 0);
    check("t4_held", bus.held, 0);

    // 5: reset while holding
    step(0, 0, 0, 1, 32'h2108_0001, 30'h20);
    step(0, 0, 1, 1, 32'h0, 30'h24);
    check("t5_held_before", bus.held, 1);
    step(1, 0, 1, 1, 32'hFFFF_FFFF, 30'h28);
    check("t5_ins", bus.id_ins, 0);
    check("t5_held", bus.held, 0);
    check("t5_stall_cnt", bus.stall_cnt, 0);

    // 6: counter saturation
    for (int k = 0; k < 5; k++)
      step(0, 0, 1, 1, $urandom, 30'($urandom));
    for (int k = 0; k < 2; k++)
      step(0, 1, 0, 1, $urandom, 30'($urandom));
`ifdef IF_ID_PERF_CNT_EN
    check("t6_stall_cnt", bus.stall_cnt, 3);
    check("t6_flush_cnt", bus.flush_cnt, 2);
`else
    check("t6_stall_cnt", bus.stall_cnt, 0);
    check("t6_flush_cnt", bus.flush_cnt, 0);
`endif

    // random traffic
    for (int k = 0; k < 500; k++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           1'($urandom),
           $urandom,
           30'($urandom));
    end

    chk_en = 0;
    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
